// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: register numbers, Status/Cause field positions,
// ExcCode values and helpers that pack the architectural register words.
package cp0_pkg;

  // CP0 register numbers used by mtc0/mfc0
  localparam logic [4:0] CP0_COUNT    = 5'd9;
  localparam logic [4:0] CP0_COMPARE  = 5'd11;
  localparam logic [4:0] CP0_STATUS   = 5'd12;
  localparam logic [4:0] CP0_CAUSE    = 5'd13;
  localparam logic [4:0] CP0_EPC      = 5'd14;
  localparam logic [4:0] CP0_ERROREPC = 5'd30;

  // Status field positions
  localparam int ST_IE    = 0;
  localparam int ST_EXL   = 1;
  localparam int ST_ERL   = 2;
  localparam int ST_IM_LO = 8;
  localparam int IM_W     = 8;

  // Cause field positions
  localparam int CA_EXC_LO = 2;
  localparam int EXC_W     = 5;
  localparam int CA_IP_LO  = 8;
  localparam int IP_W      = 8;
  localparam int CA_TI     = 30;
  localparam int CA_BD     = 31;

  // Hardware interrupt lines occupy IP[2..7]
  localparam int HW_IP_MAX = 6;
  localparam int SW_IP_W   = 2;

  typedef enum logic [4:0] {
    EXC_INT  = 5'd0,
    EXC_ADEL = 5'd4,
    EXC_ADES = 5'd5,
    EXC_SYS  = 5'd8,
    EXC_BP   = 5'd9,
    EXC_RI   = 5'd10,
    EXC_OV   = 5'd12
  } exc_code_e;

  typedef struct packed {
    logic [IM_W-1:0] im;
    logic            erl;
    logic            exl;
    logic            ie;
  } status_t;

  // Status as seen by mfc0; unimplemented bits read as zero
  function automatic logic [31:0] status_word(input status_t s);
    logic [31:0] w;
    w = '0;
    w[ST_IE]                = s.ie;
    w[ST_EXL]               = s.exl;
    w[ST_ERL]               = s.erl;
    w[ST_IM_LO +: IM_W]     = s.im;
    return w;
  endfunction

  // Cause as seen by mfc0; unimplemented bits read as zero
  function automatic logic [31:0] cause_word(input logic bd, input logic ti,
                                             input logic [IP_W-1:0] ip,
                                             input logic [EXC_W-1:0] exc);
    logic [31:0] w;
    w = '0;
    w[CA_BD]                = bd;
    w[CA_TI]                = ti;
    w[CA_IP_LO +: IP_W]     = ip;
    w[CA_EXC_LO +: EXC_W]   = exc;
    return w;
  endfunction

endpackage

// File: rtl/cp0_if.sv
// Bus between the core (decode, trap unit, PC mux) and coprocessor 0.
// master = core side, slave = CP0.
interface cp0_if #(
  parameter int DATA_W   = 32,
  parameter int N_HW_IRQ = 6
);
  logic [4:0]          cp0_rd;
  logic                mtc0_we;
  logic [DATA_W-1:0]   w_data;
  logic [DATA_W-1:0]   r_data;
  logic                di;
  logic                ei;
  logic                eret;
  logic                exc_valid;
  logic [4:0]          exc_code;
  logic [DATA_W-1:0]   exc_pc;
  logic                exc_bd;
  logic [N_HW_IRQ-1:0] irq_in;
  logic                intr_req;
  logic [DATA_W-1:0]   epc_out;
  logic [DATA_W-1:0]   exc_vector;

  modport master (
    output cp0_rd, mtc0_we, w_data, di, ei, eret,
           exc_valid, exc_code, exc_pc, exc_bd, irq_in,
    input  r_data, intr_req, epc_out, exc_vector
  );

  modport slave (
    input  cp0_rd, mtc0_we, w_data, di, ei, eret,
           exc_valid, exc_code, exc_pc, exc_bd, irq_in,
    output r_data, intr_req, epc_out, exc_vector
  );
endinterface

// File: rtl/cp0_timer.sv
// Count/Compare timer. Count advances once per COUNT_DIV clocks using a
// down-counting prescaler; TI latches when Count takes a value equal to Compare.
module cp0_timer #(
  parameter int DATA_W    = 32,
  parameter int COUNT_DIV = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              i_count_we,
  input  logic              i_compare_we,
  input  logic [DATA_W-1:0] i_w_data,
  output logic [DATA_W-1:0] o_count,
  output logic [DATA_W-1:0] o_compare,
  output logic              o_ti
);

  localparam int              PRE_W    = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LOAD = PRE_W'(COUNT_DIV - 1);

  logic [PRE_W-1:0]  r_presc;
  logic [DATA_W-1:0] r_count;
  logic [DATA_W-1:0] r_compare;
  logic              r_ti;

  logic              w_presc_tc;
  logic              w_count_upd;
  logic [DATA_W-1:0] w_count_d;

  assign w_presc_tc = (r_presc == '0);

  // Next Count: a software load wins over the prescaler tick
  always_comb begin
    w_count_d   = r_count;
    w_count_upd = 1'b0;
    if (i_count_we) begin
      w_count_d   = i_w_data;
      w_count_upd = 1'b1;
    end else if (w_presc_tc) begin
      w_count_d   = r_count + DATA_W'(1);
      w_count_upd = 1'b1;
    end
  end

  // Prescaler restarts its full period on wrap and on any Count load
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_presc <= PRE_LOAD;
    end else if (i_count_we || w_presc_tc) begin
      r_presc <= PRE_LOAD;
    end else begin
      r_presc <= r_presc - PRE_W'(1);
    end
  end

  // Count and Compare registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_count   <= '0;
      r_compare <= '0;
    end else begin
      r_count <= w_count_d;
      if (i_compare_we) begin
        r_compare <= i_w_data;
      end
    end
  end

  // TI: a Compare write clears it and masks a coincident match
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_ti <= 1'b0;
    end else if (i_compare_we) begin
      r_ti <= 1'b0;
    end else if (w_count_upd && (w_count_d == r_compare)) begin
      r_ti <= 1'b1;
    end
  end

  assign o_count   = r_count;
  assign o_compare = r_compare;
  assign o_ti      = r_ti;

endmodule

// File: rtl/cp0_ctrl.sv
// Coprocessor 0 for the single-cycle MIPS core: Status, Cause, EPC, ErrorEPC,
// the Count/Compare timer, hardware/software interrupts and exception entry.
module cp0_ctrl import cp0_pkg::*; #(
  parameter int          DATA_W     = 32,
  parameter int          N_HW_IRQ   = 6,
  parameter int          COUNT_DIV  = 2,
  parameter logic [31:0] RESET_EPC  = 32'h0040_0024,
  parameter logic [31:0] EXC_VECTOR = 32'h0040_0180
) (
  input  logic clock,
  input  logic reset,
  cp0_if.slave bus
);

  // Status state
  logic               r_ie;
  logic               r_exl;
  logic               r_erl;
  logic [IM_W-1:0]    r_im;

  // Cause / exception state
  logic               r_bd;
  logic [EXC_W-1:0]   r_exc_code;
  logic [SW_IP_W-1:0] r_sw_ip;
  logic [N_HW_IRQ-1:0] r_irq;
  logic [DATA_W-1:0]  r_epc;
  logic [DATA_W-1:0]  r_errorepc;

  // Next-state Status fields
  logic               w_ie_d;
  logic               w_exl_d;
  logic               w_erl_d;
  logic [IM_W-1:0]    w_im_d;

  logic               w_wr_count;
  logic               w_wr_compare;
  logic               w_wr_status;
  logic               w_wr_cause;
  logic               w_wr_epc;
  logic               w_wr_errorepc;

  logic [DATA_W-1:0]  w_count;
  logic [DATA_W-1:0]  w_compare;
  logic               w_ti;
  logic [HW_IP_MAX-1:0] w_hw_ip;
  logic [IP_W-1:0]    w_ip;
  status_t            w_status;

  assign w_wr_count    = bus.mtc0_we && (bus.cp0_rd == CP0_COUNT);
  assign w_wr_compare  = bus.mtc0_we && (bus.cp0_rd == CP0_COMPARE);
  assign w_wr_status   = bus.mtc0_we && (bus.cp0_rd == CP0_STATUS);
  assign w_wr_cause    = bus.mtc0_we && (bus.cp0_rd == CP0_CAUSE);
  assign w_wr_epc      = bus.mtc0_we && (bus.cp0_rd == CP0_EPC);
  assign w_wr_errorepc = bus.mtc0_we && (bus.cp0_rd == CP0_ERROREPC);

  cp0_timer #(
    .DATA_W    (DATA_W),
    .COUNT_DIV (COUNT_DIV)
  ) u_timer (
    .clock        (clock),
    .reset        (reset),
    .i_count_we   (w_wr_count),
    .i_compare_we (w_wr_compare),
    .i_w_data     (bus.w_data),
    .o_count      (w_count),
    .o_compare    (w_compare),
    .o_ti         (w_ti)
  );

  // Status update priority: exception, then eret, then mtc0, then di/ei
  always_comb begin
    w_ie_d  = r_ie;
    w_exl_d = r_exl;
    w_erl_d = r_erl;
    w_im_d  = r_im;
    if (bus.exc_valid) begin
      w_exl_d = 1'b1;
    end else if (bus.eret) begin
      if (r_erl) begin
        w_erl_d = 1'b0;
      end else begin
        w_exl_d = 1'b0;
      end
    end else if (w_wr_status) begin
      w_ie_d  = bus.w_data[ST_IE];
      w_exl_d = bus.w_data[ST_EXL];
      w_erl_d = bus.w_data[ST_ERL];
      w_im_d  = bus.w_data[ST_IM_LO +: IM_W];
    end else if (bus.di) begin
      w_ie_d = 1'b0;
    end else if (bus.ei) begin
      w_ie_d = 1'b1;
    end
  end

  // Status register; reset leaves the core in error level
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_ie  <= 1'b0;
      r_exl <= 1'b0;
      r_erl <= 1'b1;
      r_im  <= '0;
    end else begin
      r_ie  <= w_ie_d;
      r_exl <= w_exl_d;
      r_erl <= w_erl_d;
      r_im  <= w_im_d;
    end
  end

  // Exception entry: EPC/BD are captured only for a non-nested exception
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_epc      <= DATA_W'(RESET_EPC);
      r_bd       <= 1'b0;
      r_exc_code <= '0;
    end else if (bus.exc_valid) begin
      r_exc_code <= bus.exc_code;
      if (!r_exl) begin
        r_epc <= bus.exc_bd ? (bus.exc_pc - DATA_W'(4)) : bus.exc_pc;
        r_bd  <= bus.exc_bd;
      end
    end else if (w_wr_epc) begin
      r_epc <= bus.w_data;
    end
  end

  // ErrorEPC has no hardware writer in this core
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_errorepc <= DATA_W'(RESET_EPC);
    end else if (w_wr_errorepc) begin
      r_errorepc <= bus.w_data;
    end
  end

  // Software interrupt bits and the one-cycle hardware interrupt sample
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_sw_ip <= '0;
      r_irq   <= '0;
    end else begin
      r_irq <= bus.irq_in;
      if (w_wr_cause) begin
        r_sw_ip <= bus.w_data[CA_IP_LO +: SW_IP_W];
      end
    end
  end

  // Pending-interrupt vector; the timer shares IP[7] with the top hardware line
  always_comb begin
    w_hw_ip                 = '0;
    w_hw_ip[N_HW_IRQ-1:0]   = r_irq;
    w_ip = {w_hw_ip[HW_IP_MAX-1] | w_ti, w_hw_ip[HW_IP_MAX-2:0], r_sw_ip};
  end

  assign w_status = '{im: r_im, erl: r_erl, exl: r_exl, ie: r_ie};

  // mfc0 read mux, combinational from cp0_rd
  always_comb begin
    bus.r_data = '0;
    case (bus.cp0_rd)
      CP0_COUNT:    bus.r_data = w_count;
      CP0_COMPARE:  bus.r_data = w_compare;
      CP0_STATUS:   bus.r_data = DATA_W'(status_word(w_status));
      CP0_CAUSE:    bus.r_data = DATA_W'(cause_word(r_bd, w_ti, w_ip, r_exc_code));
      CP0_EPC:      bus.r_data = r_epc;
      CP0_ERROREPC: bus.r_data = r_errorepc;
      default:      bus.r_data = '0;
    endcase
  end

  assign bus.intr_req   = r_ie & ~r_exl & ~r_erl & (|(w_ip & r_im));
  assign bus.epc_out    = r_erl ? r_errorepc : r_epc;
  assign bus.exc_vector = DATA_W'(EXC_VECTOR);

endmodule

// File: tb/tb_cp0_ctrl.sv
// Self-checking bench for cp0_ctrl. Expected values are queued as stimulus is
// applied and compared once the DUT has produced the corresponding output.
module tb_cp0_ctrl;
  import cp0_pkg::*;

  localparam int          DATA_W     = 32;
  localparam int          N_HW_IRQ   = 6;
  localparam int          COUNT_DIV  = 2;
  localparam logic [31:0] RESET_EPC  = 32'h0040_0024;
  localparam logic [31:0] EXC_VECTOR = 32'h0040_0180;

  localparam int K_REG   = 0;
  localparam int K_IRQ   = 1;
  localparam int K_EPC   = 2;
  localparam int K_VEC   = 3;
  localparam int K_RDATA = 4;

  localparam logic [31:0] M_ALL   = 32'hFFFF_FFFF;
  localparam logic [31:0] M_IP    = 32'h0000_FF00;
  localparam logic [31:0] M_TI    = 32'h4000_0000;
  localparam logic [31:0] M_EXC   = 32'h8000_007C;

  logic clock = 1'b0;
  logic reset = 1'b1;

  int n_cmp = 0;
  int n_bad = 0;

  string       sb_tag[$];
  int          sb_kind[$];
  logic [4:0]  sb_rd[$];
  logic [31:0] sb_mask[$];
  logic [31:0] sb_exp[$];

  cp0_if #(.DATA_W(DATA_W), .N_HW_IRQ(N_HW_IRQ)) bus ();

  cp0_ctrl #(
    .DATA_W     (DATA_W),
    .N_HW_IRQ   (N_HW_IRQ),
    .COUNT_DIV  (COUNT_DIV),
    .RESET_EPC  (RESET_EPC),
    .EXC_VECTOR (EXC_VECTOR)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #20 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic exp_reg(input string tag, input logic [4:0] rd,
                         input logic [31:0] mask, input logic [31:0] exp);
    sb_tag.push_back(tag);
    sb_kind.push_back(K_REG);
    sb_rd.push_back(rd);
    sb_mask.push_back(mask);
    sb_exp.push_back(exp);
  endtask

  task automatic exp_sig(input string tag, input int kind, input logic [31:0] exp);
    sb_tag.push_back(tag);
    sb_kind.push_back(kind);
    sb_rd.push_back(5'd0);
    sb_mask.push_back(M_ALL);
    sb_exp.push_back(exp);
  endtask

  task automatic drain();
    string       t;
    int          k;
    logic [4:0]  rd;
    logic [31:0] m;
    logic [31:0] e;
    logic [31:0] o;
    while (sb_tag.size() > 0) begin
      t  = sb_tag.pop_front();
      k  = sb_kind.pop_front();
      rd = sb_rd.pop_front();
      m  = sb_mask.pop_front();
      e  = sb_exp.pop_front();
      if (k == K_REG) bus.cp0_rd = rd;
      #1;
      case (k)
        K_REG:   o = bus.r_data & m;
        K_IRQ:   o = {31'b0, bus.intr_req};
        K_EPC:   o = bus.epc_out;
        K_VEC:   o = bus.exc_vector;
        default: o = bus.r_data;
      endcase
      chk(t, o, e);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    bus.mtc0_we   = 1'b0;
    bus.di        = 1'b0;
    bus.ei        = 1'b0;
    bus.eret      = 1'b0;
    bus.exc_valid = 1'b0;
    bus.exc_bd    = 1'b0;
  endtask

  task automatic set_mtc0(input logic [4:0] rd, input logic [31:0] data);
    bus.cp0_rd  = rd;
    bus.w_data  = data;
    bus.mtc0_we = 1'b1;
  endtask

  task automatic mtc0(input logic [4:0] rd, input logic [31:0] data);
    set_mtc0(rd, data);
    tick();
  endtask

  task automatic set_exc(input logic [4:0] code, input logic [31:0] pc, input logic bd);
    bus.exc_valid = 1'b1;
    bus.exc_code  = code;
    bus.exc_pc    = pc;
    bus.exc_bd    = bd;
  endtask

  initial begin
    bus.cp0_rd    = '0;
    bus.mtc0_we   = 1'b0;
    bus.w_data    = '0;
    bus.di        = 1'b0;
    bus.ei        = 1'b0;
    bus.eret      = 1'b0;
    bus.exc_valid = 1'b0;
    bus.exc_code  = '0;
    bus.exc_pc    = '0;
    bus.exc_bd    = 1'b0;
    bus.irq_in    = '0;

    // Reset state
    repeat (2) @(posedge clock);
    #3;
    exp_reg("rst_status", CP0_STATUS, M_ALL, 32'h0000_0004);
    exp_reg("rst_cause", CP0_CAUSE, M_ALL, 32'h0);
    exp_reg("rst_count", CP0_COUNT, M_ALL, 32'h0);
    exp_reg("rst_compare", CP0_COMPARE, M_ALL, 32'h0);
    exp_reg("rst_epc", CP0_EPC, M_ALL, RESET_EPC);
    exp_reg("rst_errorepc", CP0_ERROREPC, M_ALL, RESET_EPC);
    exp_reg("unmapped_rd5", 5'd5, M_ALL, 32'h0);
    exp_sig("rst_intr", K_IRQ, 32'h0);
    exp_sig("exc_vector", K_VEC, EXC_VECTOR);
    drain();
    reset = 1'b0;

    // Interrupt raised, then asynchronous reset mid-cycle
    bus.irq_in[0] = 1'b1;
    set_mtc0(CP0_STATUS, 32'h0000_0401);
    exp_sig("mfc0_old_status", K_RDATA, 32'h0000_0004);
    drain();
    tick();
    exp_reg("status_401", CP0_STATUS, M_ALL, 32'h0000_0401);
    exp_reg("cause_ip2", CP0_CAUSE, M_IP, 32'h0000_0400);
    exp_sig("intr_on", K_IRQ, 32'h1);
    drain();
    mtc0(CP0_EPC, 32'h0000_1234);
    repeat (5) tick();
    @(posedge clock);
    #7;
    reset = 1'b1;
    exp_reg("arst_status", CP0_STATUS, M_ALL, 32'h0000_0004);
    exp_reg("arst_epc", CP0_EPC, M_ALL, RESET_EPC);
    exp_reg("arst_count", CP0_COUNT, M_ALL, 32'h0);
    exp_sig("arst_intr", K_IRQ, 32'h0);
    drain();
    #3;
    reset = 1'b0;

    // Interrupt exception entry; mtc0 Status in the same cycle is dropped
    mtc0(CP0_STATUS, 32'h0000_0401);
    exp_sig("intr_on2", K_IRQ, 32'h1);
    exp_reg("cause_ip2_b", CP0_CAUSE, M_IP, 32'h0000_0400);
    drain();
    set_exc(EXC_INT, 32'h0040_0100, 1'b0);
    set_mtc0(CP0_STATUS, 32'h0000_FF00);
    tick();
    exp_reg("exc_epc", CP0_EPC, M_ALL, 32'h0040_0100);
    exp_reg("exc_status", CP0_STATUS, M_ALL, 32'h0000_0403);
    exp_reg("exc_cause", CP0_CAUSE, M_EXC, 32'h0);
    exp_sig("exc_intr_off", K_IRQ, 32'h0);
    exp_sig("exc_epc_out", K_EPC, 32'h0040_0100);
    drain();
    bus.irq_in = '0;
    bus.eret = 1'b1;
    exp_sig("eret_epc_out", K_EPC, 32'h0040_0100);
    drain();
    tick();
    exp_reg("eret_status", CP0_STATUS, M_ALL, 32'h0000_0401);
    exp_sig("eret_intr", K_IRQ, 32'h0);
    drain();

    // Delay-slot exception, then a nested one
    set_exc(EXC_OV, 32'h0040_0208, 1'b1);
    tick();
    exp_reg("bd_epc", CP0_EPC, M_ALL, 32'h0040_0204);
    exp_reg("bd_cause", CP0_CAUSE, M_EXC, 32'h8000_0030);
    drain();
    set_exc(EXC_SYS, 32'h0040_0300, 1'b0);
    tick();
    exp_reg("nest_epc", CP0_EPC, M_ALL, 32'h0040_0204);
    exp_reg("nest_cause", CP0_CAUSE, M_EXC, 32'h8000_0020);
    exp_reg("nest_status", CP0_STATUS, M_ALL, 32'h0000_0403);
    drain();

    // Cause write mask, software interrupts, di/ei
    mtc0(CP0_CAUSE, 32'hFFFF_FFFF);
    exp_reg("cause_sw_only", CP0_CAUSE, M_IP, 32'h0000_0300);
    drain();
    mtc0(CP0_STATUS, 32'h0000_0100);
    exp_sig("sw_intr_ie0", K_IRQ, 32'h0);
    drain();
    bus.ei = 1'b1;
    tick();
    exp_reg("ei_status", CP0_STATUS, M_ALL, 32'h0000_0101);
    exp_sig("sw_intr_on", K_IRQ, 32'h1);
    drain();
    bus.di = 1'b1;
    tick();
    exp_reg("di_status", CP0_STATUS, M_ALL, 32'h0000_0100);
    exp_sig("di_intr_off", K_IRQ, 32'h0);
    drain();
    set_mtc0(CP0_STATUS, 32'h0000_0200);
    bus.ei = 1'b1;
    tick();
    exp_reg("mtc0_over_ei", CP0_STATUS, M_ALL, 32'h0000_0200);
    drain();
    mtc0(CP0_CAUSE, 32'h0);
    exp_reg("cause_sw_clr", CP0_CAUSE, M_IP, 32'h0);
    drain();

    // Timer match with COUNT_DIV=2
    mtc0(CP0_COUNT, 32'h0);
    mtc0(CP0_COMPARE, 32'd5);
    repeat (8) tick();
    exp_reg("cnt_4", CP0_COUNT, M_ALL, 32'd4);
    exp_reg("ti_not_yet", CP0_CAUSE, M_TI, 32'h0);
    drain();
    tick();
    exp_reg("cnt_5", CP0_COUNT, M_ALL, 32'd5);
    exp_reg("ti_set", CP0_CAUSE, M_TI, M_TI);
    drain();
    mtc0(CP0_COMPARE, 32'd20);
    exp_reg("ti_clr", CP0_CAUSE, M_TI, 32'h0);
    exp_reg("compare_20", CP0_COMPARE, M_ALL, 32'd20);
    drain();

    // Count wrap, with and without Compare=0
    mtc0(CP0_COUNT, 32'hFFFF_FFFF);
    tick();
    exp_reg("cnt_max", CP0_COUNT, M_ALL, 32'hFFFF_FFFF);
    drain();
    tick();
    exp_reg("cnt_wrap", CP0_COUNT, M_ALL, 32'h0);
    exp_reg("wrap_no_ti", CP0_CAUSE, M_TI, 32'h0);
    drain();
    mtc0(CP0_COMPARE, 32'h0);
    mtc0(CP0_COUNT, 32'hFFFF_FFFF);
    tick();
    exp_reg("ti_pre_wrap", CP0_CAUSE, M_TI, 32'h0);
    drain();
    tick();
    exp_reg("cnt_wrap2", CP0_COUNT, M_ALL, 32'h0);
    exp_reg("wrap_ti_ip7", CP0_CAUSE, 32'h4000_8000, 32'h4000_8000);
    drain();

    // eret at error level, then exception level, then eret over mtc0
    mtc0(CP0_ERROREPC, 32'h0040_0500);
    mtc0(CP0_EPC, 32'h0040_0600);
    mtc0(CP0_STATUS, 32'h0000_0006);
    bus.eret = 1'b1;
    exp_sig("eret_erl_target", K_EPC, 32'h0040_0500);
    drain();
    tick();
    exp_reg("eret_erl_status", CP0_STATUS, M_ALL, 32'h0000_0002);
    drain();
    bus.eret = 1'b1;
    exp_sig("eret_exl_target", K_EPC, 32'h0040_0600);
    drain();
    tick();
    exp_reg("eret_exl_status", CP0_STATUS, M_ALL, 32'h0);
    drain();
    mtc0(CP0_STATUS, 32'h0000_0002);
    set_mtc0(CP0_STATUS, 32'h0000_FF05);
    bus.eret = 1'b1;
    tick();
    exp_reg("eret_over_mtc0", CP0_STATUS, M_ALL, 32'h0);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
